// File: rtl/rggen_rtl_pkg.sv
// Shared types for the register access initiator: access kinds, response
// status codes, the initiator FSM states and a helper for counter sizing.
package rggen_rtl_pkg;

   typedef enum logic [1:0] {
      RGGEN_READ  = 2'b10,
      RGGEN_WRITE = 2'b11
   } rggen_access_t;

   typedef enum logic [1:0] {
      RGGEN_OKAY   = 2'b00,
      RGGEN_EXOKAY = 2'b01,
      RGGEN_SLVERR = 2'b10,
      RGGEN_DECERR = 2'b11
   } rggen_status_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_ACCESS  = 2'b01,
      ST_RESPOND = 2'b10
   } initiator_state_t;

   // Counter must hold 0..cycles; a disabled timeout still gets a 1-bit counter.
   function automatic int timeout_count_width(int cycles);
      return (cycles > 0) ? $clog2(cycles + 1) : 1;
   endfunction

endpackage

// File: rtl/rggen_register_access_initiator_if.sv
// Host request/response channel plus the register fan-out/fan-in bundle.
// Signal directions in the names are as seen from the initiator.
interface rggen_register_access_initiator_if #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int BUS_WIDTH     = 32,
   parameter int REGISTERS     = 1
);
   logic                           i_host_valid;
   logic                           o_host_ready;
   logic [ADDRESS_WIDTH-1:0]       i_host_address;
   logic                           i_host_write;
   logic [BUS_WIDTH-1:0]           i_host_write_data;
   logic [BUS_WIDTH-1:0]           i_host_mask;
   logic                           o_host_resp_valid;
   logic                           i_host_resp_ready;
   logic [1:0]                     o_host_status;
   logic [BUS_WIDTH-1:0]           o_host_read_data;
   logic                           o_register_valid;
   logic [1:0]                     o_register_access;
   logic [ADDRESS_WIDTH-1:0]       o_register_address;
   logic [BUS_WIDTH-1:0]           o_register_write_data;
   logic [BUS_WIDTH-1:0]           o_register_mask;
   logic [REGISTERS-1:0]           i_register_active;
   logic [REGISTERS-1:0]           i_register_ready;
   logic [2*REGISTERS-1:0]         i_register_status;
   logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data;

   // Initiator view
   modport master (
      input  i_host_valid, i_host_address, i_host_write, i_host_write_data, i_host_mask,
      input  i_host_resp_ready,
      output o_host_ready, o_host_resp_valid, o_host_status, o_host_read_data,
      output o_register_valid, o_register_access, o_register_address,
      output o_register_write_data, o_register_mask,
      input  i_register_active, i_register_ready, i_register_status, i_register_read_data
   );

   // Host and register responders view
   modport slave (
      output i_host_valid, i_host_address, i_host_write, i_host_write_data, i_host_mask,
      output i_host_resp_ready,
      input  o_host_ready, o_host_resp_valid, o_host_status, o_host_read_data,
      input  o_register_valid, o_register_access, o_register_address,
      input  o_register_write_data, o_register_mask,
      output i_register_active, i_register_ready, i_register_status, i_register_read_data
   );
endinterface

// File: rtl/rggen_register_response_mux.sv
// Fan-in of register responses: only registers that are both active and ready
// contribute; their status and read data are OR-combined.
module rggen_register_response_mux
   import rggen_rtl_pkg::*;
#(
   parameter int REGISTERS = 1,
   parameter int BUS_WIDTH = 32
) (
   input  logic [REGISTERS-1:0]           i_active,
   input  logic [REGISTERS-1:0]           i_ready,
   input  logic [2*REGISTERS-1:0]         i_status,
   input  logic [BUS_WIDTH*REGISTERS-1:0] i_read_data,
   output logic                           o_hit,
   output logic                           o_done,
   output rggen_status_t                  o_status,
   output logic [BUS_WIDTH-1:0]           o_read_data
);
   logic [REGISTERS-1:0] select;
   logic [1:0]           status_or;

   assign select   = i_active & i_ready;
   assign o_hit    = |i_active;
   assign o_done   = |select;
   assign o_status = rggen_status_t'(status_or);

   // OR-reduce the responses of the selected registers
   always_comb begin
      status_or   = '0;
      o_read_data = '0;
      for (int i = 0; i < REGISTERS; i++) begin
         if (select[i]) begin
            status_or   = status_or | i_status[2*i+:2];
            o_read_data = o_read_data | i_read_data[BUS_WIDTH*i+:BUS_WIDTH];
         end
      end
   end
endmodule

// File: rtl/rggen_register_access_initiator.sv
// Initiator end of the register access protocol: one outstanding access,
// broadcast to all registers, with decode-error and timeout termination.
module rggen_register_access_initiator
   import rggen_rtl_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 8,
   parameter int BUS_WIDTH      = 32,
   parameter int REGISTERS      = 1,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic i_clk,
   input logic i_rst,
   rggen_register_access_initiator_if.master bus_if
);
   localparam int                CW           = timeout_count_width(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]     TIMEOUT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   initiator_state_t           state_q, state_d;
   logic [1:0]                 access_q, access_d;
   logic [ADDRESS_WIDTH-1:0]   address_q, address_d;
   logic [BUS_WIDTH-1:0]       write_data_q, write_data_d;
   logic [BUS_WIDTH-1:0]       mask_q, mask_d;
   rggen_status_t              status_q, status_d;
   logic [BUS_WIDTH-1:0]       read_data_q, read_data_d;
   logic [CW-1:0]              count_q, count_d;

   logic                       hit;
   logic                       done;
   logic                       timeout_hit;
   rggen_status_t              mux_status;
   logic [BUS_WIDTH-1:0]       mux_read_data;

   rggen_register_response_mux #(
      .REGISTERS (REGISTERS),
      .BUS_WIDTH (BUS_WIDTH)
   ) u_response_mux (
      .i_active    (bus_if.i_register_active),
      .i_ready     (bus_if.i_register_ready),
      .i_status    (bus_if.i_register_status),
      .i_read_data (bus_if.i_register_read_data),
      .o_hit       (hit),
      .o_done      (done),
      .o_status    (mux_status),
      .o_read_data (mux_read_data)
   );

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_timeout
         assign timeout_hit = (count_q == TIMEOUT_LAST);
      end else begin : g_no_timeout
         assign timeout_hit = 1'b0;
      end
   endgenerate

   // Next-state, request latching, timeout counting and response capture
   always_comb begin
      state_d      = state_q;
      access_d     = access_q;
      address_d    = address_q;
      write_data_d = write_data_q;
      mask_d       = mask_q;
      status_d     = status_q;
      read_data_d  = read_data_q;
      count_d      = count_q;
      case (state_q)
         ST_IDLE: begin
            count_d = '0;
            if (bus_if.i_host_valid) begin
               state_d      = ST_ACCESS;
               access_d     = bus_if.i_host_write ? RGGEN_WRITE : RGGEN_READ;
               address_d    = bus_if.i_host_address;
               write_data_d = bus_if.i_host_write_data;
               mask_d       = bus_if.i_host_mask;
            end
         end
         ST_ACCESS: begin
            if (count_q != '1) begin
               count_d = count_q + CW'(1);
            end
            // A completing register wins over decode error and timeout
            if (done) begin
               state_d     = ST_RESPOND;
               status_d    = mux_status;
               read_data_d = (access_q == RGGEN_WRITE) ? '0 : mux_read_data;
            end else if (!hit) begin
               state_d     = ST_RESPOND;
               status_d    = RGGEN_DECERR;
               read_data_d = '0;
            end else if (timeout_hit) begin
               state_d     = ST_RESPOND;
               status_d    = RGGEN_SLVERR;
               read_data_d = '0;
            end
         end
         ST_RESPOND: begin
            if (bus_if.i_host_resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         access_q     <= '0;
         address_q    <= '0;
         write_data_q <= '0;
         mask_q       <= '0;
         status_q     <= RGGEN_OKAY;
         read_data_q  <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         access_q     <= access_d;
         address_q    <= address_d;
         write_data_q <= write_data_d;
         mask_q       <= mask_d;
         status_q     <= status_d;
         read_data_q  <= read_data_d;
         count_q      <= count_d;
      end
   end

   assign bus_if.o_host_ready          = (state_q == ST_IDLE);
   assign bus_if.o_host_resp_valid     = (state_q == ST_RESPOND);
   assign bus_if.o_host_status         = status_q;
   assign bus_if.o_host_read_data      = read_data_q;
   assign bus_if.o_register_valid      = (state_q == ST_ACCESS);
   assign bus_if.o_register_access     = access_q;
   assign bus_if.o_register_address    = address_q;
   assign bus_if.o_register_write_data = write_data_q;
   assign bus_if.o_register_mask       = mask_q;
endmodule

// File: tb/tb_rggen_register_access_initiator.sv
// Bench for the register access initiator: directed vector table, a reset
// sequence mid-access, and random transactions checked against a model.
module tb_rggen_register_access_initiator;
   localparam int AW  = 8;
   localparam int BW  = 32;
   localparam int NR  = 4;
   localparam int TMO = 4;

   typedef struct {
      logic            write;
      logic [AW-1:0]   addr;
      logic [BW-1:0]   wdata;
      logic [BW-1:0]   mask;
      logic [NR-1:0]   active;
      int              delay;      // ACCESS cycle index at which ready rises
      logic [2*NR-1:0] stv;
      logic [BW*NR-1:0] dv;
      int              resp_wait;  // cycles resp_ready is held low
      logic [1:0]      exp_st;
      logic [BW-1:0]   exp_data;
      int              exp_cycles; // cycles o_register_valid stays high
   } vec_t;

   logic clk;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[7];

   rggen_register_access_initiator_if #(
      .ADDRESS_WIDTH (AW), .BUS_WIDTH (BW), .REGISTERS (NR)
   ) bus_if ();

   rggen_register_access_initiator #(
      .ADDRESS_WIDTH  (AW),
      .BUS_WIDTH      (BW),
      .REGISTERS      (NR),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .bus_if (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t make_vec(input logic wr, input logic [AW-1:0] a, input logic [BW-1:0] wd,
                                     input logic [BW-1:0] m, input logic [NR-1:0] act, input int dly,
                                     input logic [2*NR-1:0] st, input logic [BW*NR-1:0] d, input int rw,
                                     input logic [1:0] est, input logic [BW-1:0] ed, input int ec);
      vec_t v;
      v.write = wr; v.addr = a; v.wdata = wd; v.mask = m; v.active = act; v.delay = dly;
      v.stv = st; v.dv = d; v.resp_wait = rw; v.exp_st = est; v.exp_data = ed; v.exp_cycles = ec;
      return v;
   endfunction

   // Reference model: outcome of one access from the protocol rules
   function automatic vec_t predict(input vec_t v);
      vec_t r = v;
      r.exp_st = 2'b00;
      r.exp_data = '0;
      if (v.active == '0) begin
         r.exp_st = 2'b11;
         r.exp_cycles = 1;
      end else if (v.delay < TMO) begin
         for (int i = 0; i < NR; i++) begin
            if (v.active[i]) begin
               r.exp_st   = r.exp_st | v.stv[2*i+:2];
               r.exp_data = r.exp_data | v.dv[BW*i+:BW];
            end
         end
         if (v.write) r.exp_data = '0;
         r.exp_cycles = v.delay + 1;
      end else begin
         r.exp_st = 2'b10;
         r.exp_cycles = TMO;
      end
      return r;
   endfunction

   task automatic clear_register_side();
      bus_if.i_register_active    = '0;
      bus_if.i_register_ready     = '0;
      bus_if.i_register_status    = '0;
      bus_if.i_register_read_data = '0;
   endtask

   task automatic run_txn(input vec_t v, input string name);
      int n;
      logic got;
      logic [1:0] exp_acc;
      exp_acc = v.write ? 2'b11 : 2'b10;
      check({name, ".host_ready_idle"}, 32'(bus_if.o_host_ready), 32'd1);
      bus_if.i_host_valid      = 1'b1;
      bus_if.i_host_write      = v.write;
      bus_if.i_host_address    = v.addr;
      bus_if.i_host_write_data = v.wdata;
      bus_if.i_host_mask       = v.mask;
      step();
      // Garbage on the host side while the access is in flight
      bus_if.i_host_write      = ~v.write;
      bus_if.i_host_address    = ~v.addr;
      bus_if.i_host_write_data = $urandom;
      bus_if.i_host_mask       = $urandom;
      n = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         check({name, ".reg_valid"}, 32'(bus_if.o_register_valid), 32'd1);
         check({name, ".reg_access"}, 32'(bus_if.o_register_access), 32'(exp_acc));
         check({name, ".reg_addr"}, 32'(bus_if.o_register_address), 32'(v.addr));
         check({name, ".reg_wdata"}, bus_if.o_register_write_data, v.wdata);
         check({name, ".reg_mask"}, bus_if.o_register_mask, v.mask);
         check({name, ".host_ready_busy"}, 32'(bus_if.o_host_ready), 32'd0);
         bus_if.i_register_active    = v.active;
         bus_if.i_register_ready     = (n >= v.delay) ? {NR{1'b1}} : {NR{1'b0}};
         bus_if.i_register_status    = v.stv;
         bus_if.i_register_read_data = v.dv;
         step();
         n++;
         got = bus_if.o_host_resp_valid;
      end
      bus_if.i_host_valid = 1'b0;
      clear_register_side();
      check({name, ".access_cycles"}, 32'(n), 32'(v.exp_cycles));
      check({name, ".reg_valid_off"}, 32'(bus_if.o_register_valid), 32'd0);
      for (int w = 0; w < v.resp_wait; w++) begin
         check({name, ".resp_valid_hold"}, 32'(bus_if.o_host_resp_valid), 32'd1);
         check({name, ".status_hold"}, 32'(bus_if.o_host_status), 32'(v.exp_st));
         check({name, ".data_hold"}, bus_if.o_host_read_data, v.exp_data);
         check({name, ".host_ready_hold"}, 32'(bus_if.o_host_ready), 32'd0);
         step();
      end
      check({name, ".resp_valid"}, 32'(bus_if.o_host_resp_valid), 32'd1);
      check({name, ".status"}, 32'(bus_if.o_host_status), 32'(v.exp_st));
      check({name, ".data"}, bus_if.o_host_read_data, v.exp_data);
      bus_if.i_host_resp_ready = 1'b1;
      step();
      bus_if.i_host_resp_ready = 1'b0;
      check({name, ".resp_done"}, 32'(bus_if.o_host_resp_valid), 32'd0);
      $display("txn %s wr=%0d addr=%h status=%0d data=%h cycles=%0d",
               name, v.write, v.addr, bus_if.o_host_status, bus_if.o_host_read_data, n);
   endtask

   initial begin
      vec_t v;
      bus_if.i_host_valid      = 1'b0;
      bus_if.i_host_write      = 1'b0;
      bus_if.i_host_address    = '0;
      bus_if.i_host_write_data = '0;
      bus_if.i_host_mask       = '0;
      bus_if.i_host_resp_ready = 1'b0;
      clear_register_side();

      vecs[0] = make_vec(1'b1, 8'h04, 32'hA5A5_0001, 32'hFFFF_FFFF, 4'b0010, 2, 8'h00,
                         {32'h0, 32'h0, 32'h5555_5555, 32'h0}, 0, 2'b00, 32'h0, 3);
      vecs[1] = make_vec(1'b0, 8'h08, 32'h0, 32'hFFFF_FFFF, 4'b0100, 0, 8'b11_00_10_01,
                         {32'h1, 32'hDEAD_BEEF, 32'h2, 32'h3}, 0, 2'b00, 32'hDEAD_BEEF, 1);
      vecs[2] = make_vec(1'b0, 8'h40, 32'h0, 32'hFFFF_FFFF, 4'b0000, 0, 8'hFF,
                         {4{32'hFFFF_FFFF}}, 0, 2'b11, 32'h0, 1);
      vecs[3] = make_vec(1'b0, 8'h10, 32'h0, 32'h0000_FFFF, 4'b0001, 100, 8'h00,
                         {4{32'h1234_5678}}, 5, 2'b10, 32'h0, 4);
      vecs[4] = make_vec(1'b0, 8'h0C, 32'h0, 32'hFFFF_FFFF, 4'b0011, 1, 8'b10_11_01_00,
                         {32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_00F0, 32'h0F00_0000},
                         1, 2'b01, 32'h0F00_00F0, 2);
      vecs[5] = make_vec(1'b0, 8'h1C, 32'h0, 32'hFFFF_FFFF, 4'b1000, 3, 8'b00_11_11_11,
                         {32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                         0, 2'b00, 32'h1234_5678, 4);
      vecs[6] = make_vec(1'b1, 8'h00, 32'hCAFE_F00D, 32'h00FF_00FF, 4'b0001, 0, 8'b00_00_00_10,
                         {4{32'hAAAA_AAAA}}, 2, 2'b10, 32'h0, 1);

      // Reset state
      rst = 1'b1;
      #1;
      step();
      step();
      check("rst.host_ready", 32'(bus_if.o_host_ready), 32'd1);
      check("rst.resp_valid", 32'(bus_if.o_host_resp_valid), 32'd0);
      check("rst.status", 32'(bus_if.o_host_status), 32'd0);
      check("rst.rdata", bus_if.o_host_read_data, 32'd0);
      check("rst.reg_valid", 32'(bus_if.o_register_valid), 32'd0);
      check("rst.reg_access", 32'(bus_if.o_register_access), 32'd0);
      check("rst.reg_addr", 32'(bus_if.o_register_address), 32'd0);
      check("rst.reg_wdata", bus_if.o_register_write_data, 32'd0);
      check("rst.reg_mask", bus_if.o_register_mask, 32'd0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 7; i++) begin
         run_txn(vecs[i], $sformatf("vec%0d", i));
      end

      // Back-to-back accesses: accept every 3 cycles at best
      bus_if.i_host_resp_ready = 1'b1;
      bus_if.i_host_valid      = 1'b1;
      bus_if.i_host_address    = 8'h08;
      bus_if.i_register_active = 4'b0001;
      bus_if.i_register_ready  = 4'b0001;
      bus_if.i_register_read_data = {96'h0, 32'h0000_0042};
      for (int c = 0; c < 6; c++) begin
         check("b2b.host_ready", 32'(bus_if.o_host_ready), 32'((c % 3) == 0));
         check("b2b.resp_valid", 32'(bus_if.o_host_resp_valid), 32'((c % 3) == 2));
         step();
      end
      bus_if.i_host_valid      = 1'b0;
      bus_if.i_host_resp_ready = 1'b0;
      clear_register_side();
      check("b2b.final_ready", 32'(bus_if.o_host_ready), 32'd1);

      // Reset in the middle of an access
      bus_if.i_host_valid   = 1'b1;
      bus_if.i_host_write   = 1'b1;
      bus_if.i_host_address = 8'h24;
      bus_if.i_host_write_data = 32'h1357_9BDF;
      bus_if.i_host_mask    = 32'hFFFF_FFFF;
      step();
      bus_if.i_host_valid      = 1'b0;
      bus_if.i_register_active = 4'b0100;
      check("mid.reg_valid", 32'(bus_if.o_register_valid), 32'd1);
      step();
      rst = 1'b1;
      #1;
      check("mid.reg_valid_rst", 32'(bus_if.o_register_valid), 32'd0);
      check("mid.reg_addr_rst", 32'(bus_if.o_register_address), 32'd0);
      check("mid.reg_access_rst", 32'(bus_if.o_register_access), 32'd0);
      check("mid.reg_wdata_rst", bus_if.o_register_write_data, 32'd0);
      check("mid.resp_valid_rst", 32'(bus_if.o_host_resp_valid), 32'd0);
      clear_register_side();
      step();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step();
         check("mid.no_resp", 32'(bus_if.o_host_resp_valid), 32'd0);
         check("mid.idle", 32'(bus_if.o_host_ready), 32'd1);
      end
      run_txn(vecs[1], "after_reset");

      // Random transactions against the reference model
      for (int t = 0; t < 40; t++) begin
         v.write  = 1'($urandom_range(0, 1));
         v.addr   = 8'($urandom);
         v.wdata  = $urandom;
         v.mask   = $urandom;
         v.active = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
         v.delay  = $urandom_range(0, 5);
         v.stv    = 8'($urandom);
         v.dv     = {$urandom, $urandom, $urandom, $urandom};
         v.resp_wait = $urandom_range(0, 3);
         v = predict(v);
         run_txn(v, $sformatf("rand%0d", t));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
